// File: rtl/spad_portb_arbiter.sv
// -----------------------------------------------------------------------------
// spad_portb_arbiter
//
// Round-robin arbiter that hands scratchpad port B to one of NUM_REQ burst
// requesters at a time. A granted requester owns the port for req_len+1 beats.
// Each beat is one port B access at an incrementing, wrapping word address.
// Write beats stall while the owner has no write data available. Read data
// comes back one cycle after issue and is tagged for the owner.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   per-requester burst request handshake (ready pulses)
//   req_we/addr/len       per-requester burst descriptor (packed slices)
//   wr_data/wr_valid      per-requester write beat data, wr_ready consumes it
//   rd_data/rd_valid      shared read data, valid tagged per requester
//   rd_last               final read beat of the burst
//   comp_*_b              scratchpad port B (1-cycle read latency)
//   busy                  a burst is in progress
//   grant_id              current or most recent owner
// -----------------------------------------------------------------------------
module spad_portb_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_REQ-1:0]            wr_valid,
  output logic [NUM_REQ-1:0]            wr_ready,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic [NUM_REQ-1:0]            rd_valid,
  output logic                          rd_last,
  output logic [ADDR_WIDTH-1:0]         comp_addr_b,
  output logic [DATA_WIDTH-1:0]         comp_din_b,
  input  logic [DATA_WIDTH-1:0]         comp_dout_b,
  output logic                          comp_en_b,
  output logic                          comp_we_b,
  output logic                          busy,
  output logic [1:0]                    grant_id
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [1:0]              rr_ptr_q, rr_ptr_d;
  logic [1:0]              owner_q, owner_d;
  logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
  logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    we_q, we_d;
  // Low for the cycle right after reset so no grant happens before the
  // requesters have seen reset released.
  logic                    rst_done_q;
  // Read-return pipeline: one entry, matches the port B read latency.
  logic                    rd_pend_q, rd_pend_d;
  logic [1:0]              rd_owner_q;
  logic                    rd_last_q, rd_last_d;

  logic                    found;
  logic [1:0]              winner;
  logic [ADDR_WIDTH-1:0]   win_addr;
  logic [LEN_WIDTH-1:0]    win_len;
  logic                    win_we;
  logic [DATA_WIDTH-1:0]   own_wdata;
  logic                    own_wvalid;
  logic                    grant_go;
  logic                    wr_go;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      int tgt;
      tgt = int'(rr_ptr_q) + off;
      if (tgt >= NUM_REQ) tgt = tgt - NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && (j == tgt) && req_valid[j]) begin
          found  = 1'b1;
          winner = 2'(j);
        end
      end
    end
  end

  // Slice muxes: winner's descriptor in IDLE, owner's write lane in BURST.
  // Slices of other requesters never reach the datapath.
  always_comb begin
    win_addr   = '0;
    win_len    = '0;
    win_we     = 1'b0;
    own_wdata  = '0;
    own_wvalid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == 2'(i)) begin
        win_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        win_len  = req_len[i*LEN_WIDTH +: LEN_WIDTH];
        win_we   = req_we[i];
      end
      if (owner_q == 2'(i)) begin
        own_wdata  = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
        own_wvalid = wr_valid[i];
      end
    end
  end

  // Next-state and port B outputs
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    cur_addr_d  = cur_addr_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    rd_pend_d   = 1'b0;
    rd_last_d   = 1'b0;
    grant_go    = 1'b0;
    wr_go       = 1'b0;
    comp_en_b   = 1'b0;
    comp_we_b   = 1'b0;
    comp_addr_b = '0;
    comp_din_b  = '0;
    busy        = 1'b0;

    case (state_q)
      IDLE: begin
        if (rst_done_q && found) begin
          grant_go   = 1'b1;
          owner_d    = winner;
          cur_addr_d = win_addr;
          cnt_d      = win_len;
          we_d       = win_we;
          state_d    = BURST;
        end
      end
      BURST: begin
        busy        = 1'b1;
        comp_addr_b = cur_addr_q;
        comp_din_b  = own_wdata;
        // Reads never stall; writes wait for the owner's data.
        if (!we_q || own_wvalid) begin
          comp_en_b  = 1'b1;
          comp_we_b  = we_q;
          wr_go      = we_q;
          cur_addr_d = cur_addr_q + ADDR_WIDTH'(1);
          cnt_d      = cnt_q - LEN_WIDTH'(1);
          rd_pend_d  = !we_q;
          rd_last_d  = (cnt_q == '0);
          if (cnt_q == '0) begin
            state_d  = IDLE;
            rr_ptr_d = (owner_q == 2'(NUM_REQ - 1)) ? 2'd0 : owner_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-requester one-hot steering of handshakes and read valid.
  always_comb begin
    req_ready = '0;
    wr_ready  = '0;
    rd_valid  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant_go && (winner == 2'(i));
      wr_ready[i]  = wr_go && (owner_q == 2'(i));
      rd_valid[i]  = rd_pend_q && (rd_owner_q == 2'(i));
    end
  end

  assign rd_data  = rd_pend_q ? comp_dout_b : '0;
  assign rd_last  = rd_pend_q && rd_last_q;
  assign grant_id = owner_q;

  // State registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      cur_addr_q <= '0;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      rst_done_q <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= '0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      cur_addr_q <= cur_addr_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      rst_done_q <= 1'b1;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= owner_q;
      rd_last_q  <= rd_last_d;
    end
  end

endmodule

// File: tb/tb_spad_portb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spad_portb_arbiter
//
// Directed bench for spad_portb_arbiter with NUM_REQ=2. A behavioural
// scratchpad (1-cycle read latency) sits on port B. Inputs change 1 time unit
// after the rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_spad_portb_arbiter;

  localparam int NR = 2;
  localparam int AW = 13;
  localparam int DW = 32;
  localparam int LW = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid, req_ready, req_we, wr_valid, wr_ready, rd_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*LW-1:0]  req_len;
  logic [NR*DW-1:0]  wr_data;
  logic [DW-1:0]     rd_data, comp_din_b, comp_dout_b;
  logic              rd_last, comp_en_b, comp_we_b, busy;
  logic [AW-1:0]     comp_addr_b;
  logic [1:0]        grant_id;

  logic              pre_we;
  logic [AW-1:0]     pre_addr;
  logic [DW-1:0]     pre_data;
  logic [DW-1:0]     mem [0:(1<<AW)-1];

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt;
  int beat;

  bit        wv   [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [AW-1:0] wexp [4] = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};

  always #5 clk = ~clk;

  spad_portb_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .comp_addr_b(comp_addr_b), .comp_din_b(comp_din_b), .comp_dout_b(comp_dout_b),
    .comp_en_b(comp_en_b), .comp_we_b(comp_we_b),
    .busy(busy), .grant_id(grant_id)
  );

  // Scratchpad model with a bench-side preload port.
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (comp_en_b && comp_we_b) mem[comp_addr_b] <= comp_din_b;
    if (comp_en_b && !comp_we_b) comp_dout_b <= mem[comp_addr_b];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = 2'b11; req_we = '0; req_addr = '0; req_len = '0;
    wr_data = '0; wr_valid = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;

    // Reset with both requesters asking; preload 0x010..0x013
    for (int k = 0; k < 4; k++) begin
      tick();
      pre_we = 1'b1; pre_addr = AW'(16 + k); pre_data = DW'(32'hA0 + k);
    end
    tick();
    pre_we = 1'b0;
    @(negedge clk);
    check_eq("rst_req_ready", req_ready, 2'b00);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_en", comp_en_b, 0);
    check_eq("rst_we", comp_we_b, 0);
    check_eq("rst_wr_ready", wr_ready, 0);
    check_eq("rst_rd_valid", rd_valid, 0);
    check_eq("rst_rd_last", rd_last, 0);
    check_eq("rst_addr", comp_addr_b, 0);
    check_eq("rst_din", comp_din_b, 0);
    check_eq("rst_rd_data", rd_data, 0);
    check_eq("rst_grant", grant_id, 0);
    tick();
    rst_n = 1'b1; req_valid = 2'b00;
    @(negedge clk);
    check_eq("post_rst_req_ready", req_ready, 2'b00);
    check_eq("post_rst_busy", busy, 0);

    // Read burst: req 0, addr 0x010, len 3
    tick();
    req_valid = 2'b01; req_we = 2'b00; req_addr[AW-1:0] = 13'h010; req_len[LW-1:0] = 8'd3;
    @(negedge clk);
    check_eq("rd_req_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("rd_req_ready_lo", req_ready, 2'b00);
      if (k < 4) begin
        check_eq("rd_en", comp_en_b, 1);
        check_eq("rd_we", comp_we_b, 0);
        check_eq("rd_addr", comp_addr_b, 64'h10 + k);
        check_eq("rd_busy", busy, 1);
      end else begin
        check_eq("rd_end_en", comp_en_b, 0);
        check_eq("rd_end_busy", busy, 0);
      end
      if (k > 0) begin
        check_eq("rd_valid", rd_valid, 2'b01);
        check_eq("rd_data", rd_data, 64'hA0 + k - 1);
        check_eq("rd_last", rd_last, (k == 4) ? 1 : 0);
      end else begin
        check_eq("rd_valid_first", rd_valid, 2'b00);
      end
      tick();
    end
    @(negedge clk);
    check_eq("rd_valid_after", rd_valid, 2'b00);

    // Write burst: req 1, addr 0x1FFE, len 3, stall 2 cycles on 2nd beat.
    // Requester 0's slices hold junk that must not leak.
    tick();
    req_valid = 2'b10; req_we = 2'b10;
    req_addr = {13'h1FFE, 13'h0AAA}; req_len = {8'd3, 8'd9};
    wr_data[DW-1:0] = 32'hDEADBEEF;
    @(negedge clk);
    check_eq("wr_req_ready", req_ready, 2'b10);
    beat = 0; wr_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 0) req_valid = 2'b00;
      wr_valid = {wv[k], 1'b1};
      wr_data[2*DW-1:DW] = 32'hB0 + 32'(beat);
      @(negedge clk);
      if (wv[k]) begin
        check_eq("wr_en", comp_en_b, 1);
        check_eq("wr_we", comp_we_b, 1);
        check_eq("wr_addr", comp_addr_b, wexp[beat]);
        check_eq("wr_din", comp_din_b, 64'hB0 + beat);
        check_eq("wr_ready", wr_ready, 2'b10);
        beat++;
      end else begin
        check_eq("wr_stall_en", comp_en_b, 0);
        check_eq("wr_stall_we", comp_we_b, 0);
        check_eq("wr_stall_ready", wr_ready, 2'b00);
        check_eq("wr_stall_busy", busy, 1);
      end
      if (wr_ready[1]) wr_cnt++;
    end
    tick();
    wr_valid = 2'b00;
    @(negedge clk);
    check_eq("wr_end_busy", busy, 0);
    check_eq("wr_end_en", comp_en_b, 0);
    check_eq("wr_ready_count", wr_cnt, 4);
    check_eq("mem_1FFE", mem[13'h1FFE], 32'hB0);
    check_eq("mem_1FFF", mem[13'h1FFF], 32'hB1);
    check_eq("mem_0000", mem[13'h0000], 32'hB2);
    check_eq("mem_0001", mem[13'h0001], 32'hB3);

    // Both held valid, len 0: grants alternate 0,1,0,1,0,1
    tick();
    req_valid = 2'b11; req_we = 2'b00; req_addr = {13'h030, 13'h020}; req_len = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_eq("rot_req_ready", req_ready, (k % 2) ? 2'b10 : 2'b01);
      tick();
      if (k == 5) req_valid = 2'b00;
      @(negedge clk);
      check_eq("rot_grant", grant_id, k % 2);
      check_eq("rot_busy", busy, 1);
      tick();
    end

    // Req 1 arrives during req 0's burst, granted right after final beat
    tick();
    req_valid = 2'b01; req_addr = {13'h030, 13'h010}; req_len = {8'd0, 8'd2};
    @(negedge clk);
    check_eq("late_req0_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b10;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("late_hold_ready", req_ready, 2'b00);
      check_eq("late_hold_grant", grant_id, 0);
      check_eq("late_hold_busy", busy, 1);
      tick();
    end
    @(negedge clk);
    check_eq("late_req1_ready", req_ready, 2'b10);
    check_eq("late_idle_busy", busy, 0);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    check_eq("late_grant1", grant_id, 1);

    // Reset on 3rd beat of a len 7 read; rr_ptr is 1 beforehand
    tick();
    req_valid = 2'b01; req_len = {8'd0, 8'd0};
    @(negedge clk);
    check_eq("pre_rr_ready0", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    tick();
    req_valid = 2'b10; req_addr = {13'h010, 13'h020}; req_len = {8'd7, 8'd0};
    @(negedge clk);
    check_eq("mid_req_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    check_eq("mid_beat1_addr", comp_addr_b, 13'h010);
    tick();
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("mid_beat3_en", comp_en_b, 1);
    check_eq("mid_beat3_addr", comp_addr_b, 13'h012);
    check_eq("mid_beat2_rd_valid", rd_valid, 2'b10);
    check_eq("mid_beat2_rd_data", rd_data, 32'hA1);
    tick();
    rst_n = 1'b1; req_valid = 2'b11; req_len = '0;
    @(negedge clk);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_rd_valid", rd_valid, 2'b00);
    check_eq("mid_rst_en", comp_en_b, 0);
    check_eq("mid_rst_rd_last", rd_last, 0);
    check_eq("mid_rst_req_ready", req_ready, 2'b00);
    check_eq("mid_rst_grant", grant_id, 0);
    tick();
    @(negedge clk);
    check_eq("post_mid_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    check_eq("post_mid_grant", grant_id, 0);
    check_eq("post_mid_busy", busy, 1);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
